// File: rtl/mips_halt_monitor.sv
// mips_halt_monitor: watches the fetch stream of mips_cpu_harvard from reset
// to halt (a jump to HALT_ADDR). After a settle window it samples register_v0
// and issues a sticky pass/fail verdict with an error code.
module mips_halt_monitor #(
    parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR      = 32'h00000000,
    parameter int unsigned SETTLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        active,
    input  logic [31:0] instr_address,
    input  logic [31:0] register_v0,
    input  logic [31:0] expected_v0,
    input  logic        check_en,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [2:0]  err_code,
    output logic [31:0] captured_v0,
    output logic [31:0] cycle_count,
    output logic [15:0] fetch_count
);

    localparam logic [2:0] ST_WAIT_START = 3'd0;
    localparam logic [2:0] ST_RUN        = 3'd1;
    localparam logic [2:0] ST_SETTLE     = 3'd2;
    localparam logic [2:0] ST_PASS       = 3'd3;
    localparam logic [2:0] ST_FAIL       = 3'd4;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_V0        = 3'd1;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd2;
    localparam logic [2:0] ERR_ALIGN     = 3'd3;
    localparam logic [2:0] ERR_START     = 3'd4;
    localparam logic [2:0] ERR_ACTIVE    = 3'd5;

    localparam logic [3:0]  SETTLE_INIT  = 4'(SETTLE_CYCLES);
    localparam logic [32:0] TIMEOUT_LIM  = 33'(TIMEOUT_CYCLES);

    logic [2:0]  r_state;
    logic [3:0]  r_settle_cnt;
    logic [31:0] r_prev_addr;
    logic [31:0] r_cycle_count;
    logic [15:0] r_fetch_count;
    logic        r_done;
    logic        r_pass;
    logic        r_fail;
    logic [2:0]  r_err_code;
    logic [31:0] r_captured_v0;

    logic [2:0]  w_state_next;
    logic        w_pass_go;
    logic        w_fail_go;
    logic [2:0]  w_err_next;
    logic        w_settle_load;
    logic        w_verdict;
    logic        w_v0_ok;
    logic        w_timeout;
    logic        w_counting;

    // Compared in 33 bits so a saturated cycle_count cannot wrap past the limit.
    assign w_timeout  = ({1'b0, r_cycle_count} + 33'd1) >= TIMEOUT_LIM;
    assign w_v0_ok    = !check_en || (register_v0 == expected_v0);
    assign w_counting = (r_state == ST_RUN) || (r_state == ST_SETTLE);

    // Next-state decision: checks evaluated in priority order for each state.
    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
        w_state_next  = r_state;
        w_pass_go     = 1'b0;
        w_fail_go     = 1'b0;
        w_err_next    = ERR_NONE;
        w_settle_load = 1'b0;
        w_verdict     = 1'b0;

        case (r_state)
            ST_WAIT_START: begin
                if (instr_address == RESET_VECTOR) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_fail_go  = 1'b1;
                    w_err_next = ERR_START;
                end
            end
            ST_RUN: begin
                if (instr_address[1:0] != 2'b00) begin
                    w_fail_go  = 1'b1;
                    w_err_next = ERR_ALIGN;
                end else if (instr_address == HALT_ADDR) begin
                    // A zero-length settle window decides on the halt edge itself.
                    if (SETTLE_INIT == 4'd0) begin
                        w_verdict = 1'b1;
                    end else begin
                        w_state_next  = ST_SETTLE;
                        w_settle_load = 1'b1;
                    end
                end else if (!active) begin
                    w_fail_go  = 1'b1;
                    w_err_next = ERR_ACTIVE;
                end else if (w_timeout) begin
                    w_fail_go  = 1'b1;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            ST_SETTLE: begin
                if (w_timeout) begin
                    w_fail_go  = 1'b1;
                    w_err_next = ERR_TIMEOUT;
                end else if (r_settle_cnt == 4'd1) begin
                    w_verdict = 1'b1;
                end
            end
            default: begin
                // PASS and FAIL are terminal.
            end
        endcase

        if (w_verdict) begin
            if (w_v0_ok) begin
                w_pass_go = 1'b1;
            end else begin
                w_fail_go  = 1'b1;
                w_err_next = ERR_V0;
            end
        end

        if (w_pass_go) begin
            w_state_next = ST_PASS;
        end else if (w_fail_go) begin
            w_state_next = ST_FAIL;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= ST_WAIT_START;
        end else if (clk_enable) begin
            r_state <= w_state_next;
        end
    end

    // Settle-window down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= 4'd0;
        end else if (clk_enable) begin
            if (w_settle_load) begin
                r_settle_cnt <= SETTLE_INIT;
            end else if (r_state == ST_SETTLE && r_settle_cnt != 4'd0) begin
                r_settle_cnt <= r_settle_cnt - 4'd1;
            end
        end
    end

    // Saturating count of enabled cycles spent in RUN and SETTLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= 32'd0;
        end else if (clk_enable && w_counting && r_cycle_count != 32'hFFFF_FFFF) begin
            r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    // Fetch tracking: the reset-vector fetch counts as the first distinct address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_addr   <= 32'd0;
            r_fetch_count <= 16'd0;
        end else if (clk_enable) begin
            if (r_state == ST_WAIT_START && !w_fail_go) begin
                r_prev_addr   <= instr_address;
                r_fetch_count <= 16'd1;
            end else if (r_state == ST_RUN) begin
                r_prev_addr <= instr_address;
                if (instr_address != r_prev_addr && r_fetch_count != 16'hFFFF) begin
                    r_fetch_count <= r_fetch_count + 16'd1;
                end
            end
        end
    end

    // Sticky verdict outputs, loaded once on entry to PASS or FAIL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_captured_v0 <= 32'd0;
        end else if (clk_enable && (w_pass_go || w_fail_go)) begin
            r_done        <= 1'b1;
            r_pass        <= w_pass_go;
            r_fail        <= w_fail_go;
            r_err_code    <= w_err_next;
            r_captured_v0 <= register_v0;
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign err_code    = r_err_code;
    assign captured_v0 = r_captured_v0;
    assign cycle_count = r_cycle_count;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_mips_halt_monitor.sv
// Bench for mips_halt_monitor: three instances (settle 1, 3, 0; timeout 20)
// share one input stream. Table vectors, a stall/reset sequence and random
// traces are compared against a trace-level reference model.
module tb_mips_halt_monitor;

    localparam logic [31:0] RV     = 32'hBFC00000;
    localparam logic [31:0] HALT   = 32'h00000000;
    localparam int          TMO    = 20;
    localparam int          NDUT   = 3;
    localparam int          MAXLEN = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        clk_enable = 1'b0;
    logic        active = 1'b0;
    logic        check_en = 1'b0;
    logic [31:0] instr_address = 32'd0;
    logic [31:0] register_v0 = 32'd0;
    logic [31:0] expected_v0 = 32'd0;

    logic [NDUT-1:0]       done_v, pass_v, fail_v;
    logic [NDUT-1:0][2:0]  err_v;
    logic [NDUT-1:0][31:0] cap_v, cc_v;
    logic [NDUT-1:0][15:0] fc_v;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mips_halt_monitor #(
            .RESET_VECTOR  (RV),
            .HALT_ADDR     (HALT),
            .SETTLE_CYCLES (g == 0 ? 1 : (g == 1 ? 3 : 0)),
            .TIMEOUT_CYCLES(TMO)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .clk_enable   (clk_enable),
            .active       (active),
            .instr_address(instr_address),
            .register_v0  (register_v0),
            .expected_v0  (expected_v0),
            .check_en     (check_en),
            .done         (done_v[g]),
            .pass         (pass_v[g]),
            .fail         (fail_v[g]),
            .err_code     (err_v[g]),
            .captured_v0  (cap_v[g]),
            .cycle_count  (cc_v[g]),
            .fetch_count  (fc_v[g])
        );
    end

    function automatic int settle_of(input int g);
        case (g)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Stimulus trace, one entry per clock edge after reset is released.
    logic        tr_en   [MAXLEN];
    logic [31:0] tr_addr [MAXLEN];
    logic        tr_act  [MAXLEN];
    logic [31:0] tr_v0   [MAXLEN];
    logic [31:0] tr_exp;
    logic        tr_chk;

    typedef struct {
        int          dec;   // trace index of the deciding edge, -1 if none
        logic        pass;
        logic        fail;
        logic [2:0]  err;
        logic [31:0] cap;
        logic [31:0] cc;
        logic [15:0] fc;
    } exp_t;

    // Reference: scan only the enabled edges. The first must fetch the reset
    // vector; after that the n-th enabled edge has cycle_count n-1 before it.
    function automatic exp_t predict(input int len, input int s);
        exp_t        r;
        int          e[$];
        int          k_end;
        int          k_h;
        int          k_t;
        int          code;
        logic [31:0] prev;
        logic [31:0] a;
        r.dec = -1; r.pass = 1'b0; r.fail = 1'b0; r.err = 3'd0;
        r.cap = 32'd0; r.cc = 32'd0; r.fc = 16'd0;
        for (int i = 0; i < len; i++) if (tr_en[i]) e.push_back(i);
        if (e.size() == 0) return r;
        if (tr_addr[e[0]] != RV) begin
            r.dec = e[0]; r.fail = 1'b1; r.err = 3'd4; r.cap = tr_v0[e[0]];
            return r;
        end
        r.fc = 16'd1; prev = RV; k_end = -1; k_h = -1; code = 0;
        for (int k = 1; k < e.size(); k++) begin
            a = tr_addr[e[k]];
            if (a != prev) r.fc = r.fc + 16'd1;
            prev = a;
            if (a[1:0] != 2'b00)   begin code = 3; k_end = k; break; end
            if (a == HALT)         begin k_h = k; break; end
            if (!tr_act[e[k]])     begin code = 5; k_end = k; break; end
            if (k >= TMO)          begin code = 2; k_end = k; break; end
        end
        if (k_h >= 0) begin
            if (s == 0) begin
                k_end = k_h; code = -1;
            end else begin
                k_t = (k_h + 1 > TMO) ? k_h + 1 : TMO;
                if (k_t <= k_h + s) begin k_end = k_t; code = 2; end
                else begin k_end = k_h + s; code = -1; end
            end
        end
        if (k_end < 0 || k_end >= e.size()) begin
            r.cc = 32'(e.size() - 1);
            return r;
        end
        r.dec = e[k_end];
        r.cc  = 32'(k_end);
        r.cap = tr_v0[e[k_end]];
        if (code < 0) begin
            if (!tr_chk || tr_v0[e[k_end]] == tr_exp) r.pass = 1'b1;
            else begin r.fail = 1'b1; r.err = 3'd1; end
        end else begin
            r.fail = 1'b1; r.err = 3'(code);
        end
        return r;
    endfunction

    // Reset with a random clk_enable, check cleared outputs, play the trace,
    // then compare every instance against the model.
    task automatic run_trace(input int len, input string tag);
        int   obs_dec[NDUT];
        int   viol;
        exp_t x;
        @(negedge clk);
        reset = 1'b1; clk_enable = 1'($urandom_range(0, 1));
        instr_address = $urandom; active = 1'b0; register_v0 = $urandom;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("%s/dut%0d/rst_flags", tag, g),
                  {26'd0, done_v[g], pass_v[g], fail_v[g], err_v[g]}, 32'd0);
            check($sformatf("%s/dut%0d/rst_cap", tag, g), cap_v[g], 32'd0);
            check($sformatf("%s/dut%0d/rst_cc", tag, g), cc_v[g], 32'd0);
            check($sformatf("%s/dut%0d/rst_fc", tag, g), {16'd0, fc_v[g]}, 32'd0);
            obs_dec[g] = -1;
        end
        reset = 1'b0; expected_v0 = tr_exp; check_en = tr_chk;
        viol = 0;
        for (int i = 0; i < len; i++) begin
            clk_enable = tr_en[i]; instr_address = tr_addr[i];
            active = tr_act[i]; register_v0 = tr_v0[i];
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                if (done_v[g] && obs_dec[g] < 0) obs_dec[g] = i;
                if ((pass_v[g] && fail_v[g]) || (done_v[g] != (pass_v[g] | fail_v[g]))) viol++;
            end
        end
        check($sformatf("%s/flag_consistency", tag), 32'(viol), 32'd0);
        for (int g = 0; g < NDUT; g++) begin
            x = predict(len, settle_of(g));
            check($sformatf("%s/dut%0d/decide_edge", tag, g), 32'(obs_dec[g]), 32'(x.dec));
            check($sformatf("%s/dut%0d/pass", tag, g), {31'd0, pass_v[g]}, {31'd0, x.pass});
            check($sformatf("%s/dut%0d/fail", tag, g), {31'd0, fail_v[g]}, {31'd0, x.fail});
            check($sformatf("%s/dut%0d/err", tag, g), {29'd0, err_v[g]}, {29'd0, x.err});
            check($sformatf("%s/dut%0d/cap", tag, g), cap_v[g], x.cap);
            check($sformatf("%s/dut%0d/cc", tag, g), cc_v[g], x.cc);
            check($sformatf("%s/dut%0d/fc", tag, g), {16'd0, fc_v[g]}, {16'd0, x.fc});
        end
    endtask

    typedef struct {
        logic [31:0] start;
        int          n_seq;   // sequential fetches before the jump to HALT
        logic        loop;    // stick at start+4 forever
        int          bad_k;   // edge whose address is 2 bytes low, -1 none
        int          drop_k;  // edge with active low, -1 none
        logic [31:0] v0;
        logic [31:0] exp_v0;
        logic        chk;
        logic        e_pass;  // expectations below are for the settle=1 instance
        logic [2:0]  e_err;
        logic [31:0] e_cc;
        logic [15:0] e_fc;
        logic [31:0] e_cap;
    } vec_t;

    localparam int NVEC = 12;
    localparam int VLEN = 32;

    task automatic step(input logic en, input logic [31:0] addr);
        clk_enable = en; instr_address = addr; active = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs[NVEC];
        logic [31:0] pc;
        int          r;

        vecs[0]  = '{RV, 3, 1'b0, -1, -1, 32'd0, 32'd0, 1'b1, 1'b1, 3'd0, 32'd4, 16'd4, 32'd0};
        vecs[1]  = '{RV, 3, 1'b0, -1, -1, 32'd0, 32'd1, 1'b1, 1'b0, 3'd1, 32'd4, 16'd4, 32'd0};
        vecs[2]  = '{RV, 3, 1'b0, -1, -1, 32'd5, 32'd1, 1'b0, 1'b1, 3'd0, 32'd4, 16'd4, 32'd5};
        vecs[3]  = '{RV, 99, 1'b1, -1, -1, 32'd7, 32'd7, 1'b1, 1'b0, 3'd2, 32'd20, 16'd2, 32'd7};
        vecs[4]  = '{32'hBFC00008, 3, 1'b0, -1, -1, 32'd9, 32'd9, 1'b1, 1'b0, 3'd4, 32'd0, 16'd0, 32'd9};
        vecs[5]  = '{RV, 4, 1'b0, 2, -1, 32'd3, 32'd3, 1'b1, 1'b0, 3'd3, 32'd2, 16'd3, 32'd3};
        vecs[6]  = '{RV, 5, 1'b0, -1, 3, 32'd4, 32'd4, 1'b1, 1'b0, 3'd5, 32'd3, 16'd4, 32'd4};
        vecs[7]  = '{RV, 2, 1'b0, -1, 2, 32'd6, 32'd6, 1'b1, 1'b1, 3'd0, 32'd3, 16'd3, 32'd6};
        vecs[8]  = '{RV, 19, 1'b0, -1, -1, 32'd1, 32'd1, 1'b1, 1'b0, 3'd2, 32'd20, 16'd20, 32'd1};
        vecs[9]  = '{RV, 18, 1'b0, -1, -1, 32'd1, 32'd1, 1'b1, 1'b1, 3'd0, 32'd19, 16'd19, 32'd1};
        vecs[10] = '{RV, 99, 1'b0, -1, -1, 32'd2, 32'd2, 1'b1, 1'b0, 3'd2, 32'd20, 16'd21, 32'd2};
        vecs[11] = '{RV, 20, 1'b0, -1, -1, 32'd8, 32'd8, 1'b1, 1'b0, 3'd2, 32'd21, 16'd21, 32'd8};

        for (int v = 0; v < NVEC; v++) begin
            for (int i = 0; i < VLEN; i++) begin
                tr_en[i]  = 1'b1;
                tr_act[i] = (i != vecs[v].drop_k);
                tr_v0[i]  = vecs[v].v0;
                if (vecs[v].loop) tr_addr[i] = (i == 0) ? vecs[v].start : vecs[v].start + 32'd4;
                else              tr_addr[i] = (i < vecs[v].n_seq) ? vecs[v].start + 32'(4 * i) : HALT;
                if (i == vecs[v].bad_k) tr_addr[i] = tr_addr[i] - 32'd2;
            end
            tr_exp = vecs[v].exp_v0;
            tr_chk = vecs[v].chk;
            run_trace(VLEN, $sformatf("vec%0d", v));
            check($sformatf("vec%0d/tbl_flags", v), {29'd0, done_v[0], pass_v[0], fail_v[0]},
                  {29'd0, 1'b1, vecs[v].e_pass, !vecs[v].e_pass});
            check($sformatf("vec%0d/tbl_err", v), {29'd0, err_v[0]}, {29'd0, vecs[v].e_err});
            check($sformatf("vec%0d/tbl_cc", v), cc_v[0], vecs[v].e_cc);
            check($sformatf("vec%0d/tbl_fc", v), {16'd0, fc_v[0]}, {16'd0, vecs[v].e_fc});
            check($sformatf("vec%0d/tbl_cap", v), cap_v[0], vecs[v].e_cap);
        end

        // Settle=3 instance: clk_enable held low for 5 cycles inside SETTLE
        // pushes the verdict from edge 5 to edge 10; then reset after pass.
        @(negedge clk);
        reset = 1'b1; clk_enable = 1'b0;
        @(negedge clk);
        reset = 1'b0; expected_v0 = 32'h2A; check_en = 1'b1; register_v0 = 32'h2A;
        step(1'b1, RV);
        step(1'b1, RV + 32'd4);
        step(1'b1, HALT);
        step(1'b1, HALT);
        check("stall/cc_before", cc_v[1], 32'd3);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0000_0006);
        check("stall/cc_held", cc_v[1], 32'd3);
        check("stall/done_held", {31'd0, done_v[1]}, 32'd0);
        step(1'b1, HALT);
        check("stall/done_edge9", {31'd0, done_v[1]}, 32'd0);
        step(1'b1, HALT);
        check("stall/done_edge10", {31'd0, done_v[1]}, 32'd1);
        check("stall/pass", {31'd0, pass_v[1]}, 32'd1);
        check("stall/err", {29'd0, err_v[1]}, 32'd0);
        check("stall/cc", cc_v[1], 32'd5);
        check("stall/fc", {16'd0, fc_v[1]}, 32'd3);
        check("stall/cap", cap_v[1], 32'h2A);
        register_v0 = 32'h55;
        step(1'b1, 32'h0000_0001);
        step(1'b1, RV);
        check("sticky/pass", {31'd0, pass_v[1]}, 32'd1);
        check("sticky/cap", cap_v[1], 32'h2A);
        check("sticky/cc", cc_v[1], 32'd5);
        reset = 1'b1; clk_enable = 1'b0;
        @(negedge clk);
        check("rst_after_pass/flags", {26'd0, done_v[1], pass_v[1], fail_v[1], err_v[1]}, 32'd0);
        check("rst_after_pass/cap", cap_v[1], 32'd0);
        check("rst_after_pass/cc", cc_v[1], 32'd0);
        check("rst_after_pass/fc", {16'd0, fc_v[1]}, 32'd0);

        // Random traces against the model.
        for (int t = 0; t < 40; t++) begin
            tr_exp = 32'($urandom_range(0, 3));
            tr_chk = ($urandom_range(0, 3) != 0);
            pc = ($urandom_range(0, 15) == 0) ? RV + 32'd4 : RV;
            for (int i = 0; i < 40; i++) begin
                tr_en[i]   = ($urandom_range(0, 3) != 0);
                tr_act[i]  = ($urandom_range(0, 39) != 0);
                tr_v0[i]   = 32'($urandom_range(0, 3));
                tr_addr[i] = pc;
                r = $urandom_range(0, 99);
                if (r < 8)       pc = HALT;
                else if (r < 10) pc = pc + 32'd2;
                else if (r < 20) pc = pc;
                else if (r < 25) pc = RV + 32'($urandom_range(0, 63) * 4);
                else             pc = pc + 32'd4;
            end
            run_trace(40, $sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_halt_monitor.md
Name: mips_halt_monitor

Overview:
- Bench-side checker that sits directly downstream of mips_cpu_harvard and consumes its instr_address, active and register_v0 outputs.
- Confirms the CPU starts at the reset vector and tracks its fetch stream.
- Detects a halt, meaning a jump to address 0, then waits a settle window and compares register_v0 against an expected value.
- Reports pass/fail with an error code, or a timeout. Replaces the ad-hoc per-test negedge assertions.

Parameters:
- RESET_VECTOR, 32'hBFC00000, address of the first fetch required after reset.
- HALT_ADDR, 32'h00000000, fetch address that signals halt.
- SETTLE_CYCLES, 1, enabled cycles to wait after halt detection before sampling register_v0 (range 0..15).
- TIMEOUT_CYCLES, 1000, maximum enabled cycles from leaving WAIT_START to the verdict.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_enable  input  1  when low, all state, counters and outputs hold.
- active  input  1  CPU active flag.
- instr_address  input  32  CPU fetch address.
- register_v0  input  32  CPU $v0 value.
- expected_v0  input  32  golden $v0; stable for the whole run.
- check_en  input  1  when 1, the verdict compares v0; when 0, reaching halt alone passes.
- done  output  1  verdict reached (sticky).
- pass  output  1  run passed (sticky).
- fail  output  1  run failed (sticky).
- err_code  output  3  0 none, 1 v0 mismatch, 2 timeout, 3 misaligned fetch, 4 bad start, 5 active dropped before halt.
- captured_v0  output  32  register_v0 sampled at the verdict.
- cycle_count  output  32  enabled cycles spent in RUN and SETTLE (saturates at 32'hFFFFFFFF).
- fetch_count  output  16  distinct fetch addresses seen, counted on each change of instr_address (saturating).

Behaviour:
- Reset (reset=1 at a clk edge, regardless of clk_enable or current state):
  - state=WAIT_START.
  - done, pass, fail = 0; err_code = 0; captured_v0 = 0; cycle_count = 0; fetch_count = 0; settle counter = 0; previous-address register = 0.
  - Reset mid-run abandons the run with no verdict.
- All transitions below occur only on edges with clk_enable=1 and reset=0.
- WAIT_START:
  - instr_address==RESET_VECTOR -> RUN; fetch_count=1; previous-address register loaded.
  - Any other address -> FAIL with err_code=4.
- RUN, checks in priority order each enabled cycle:
  1. instr_address[1:0]!=0 -> FAIL, err_code=3.
  2. instr_address==HALT_ADDR -> SETTLE; settle counter loaded with SETTLE_CYCLES. If SETTLE_CYCLES=0, go to the verdict directly in this same edge.
  3. active==0 -> FAIL, err_code=5.
  4. cycle_count+1 >= TIMEOUT_CYCLES -> FAIL, err_code=2.
  5. Otherwise stay in RUN.
  - cycle_count increments on every enabled cycle in RUN and SETTLE, including the cycle that transitions.
  - fetch_count increments when instr_address differs from the previous-address register, then the register is updated. The halt fetch counts.
- SETTLE:
  - Settle counter decrements each enabled cycle.
  - Timeout has priority over expiry: cycle_count+1 >= TIMEOUT_CYCLES -> FAIL, err_code=2.
  - On the cycle the counter equals 1: verdict.
  - active and alignment are not checked in SETTLE.
- Verdict:
  - captured_v0 <= register_v0.
  - check_en=0, or register_v0==expected_v0 -> PASS: pass=1, done=1, err_code=0.
  - Otherwise FAIL: fail=1, done=1, err_code=1.
- PASS and FAIL are terminal. Outputs are sticky until reset, and counters freeze.
- All FAIL entries set fail=1, done=1 and the listed err_code. captured_v0 is also loaded on every FAIL entry.
- pass and fail are never both 1. done = pass|fail.
- Outputs are registered; a verdict is visible the cycle after the deciding edge.

Test Plan:
- Program li $a0,77; slti $v0,$a0,-11 result 0; jr $0. With expected_v0=0, check_en=1 -> pass=1, err_code=0, captured_v0=0, fetch_count=4.
- Same program, expected_v0=1 -> fail=1, err_code=1, captured_v0=0, done=1.
- CPU loops at 32'hBFC00004 forever, TIMEOUT_CYCLES=20 -> fail=1, err_code=2, cycle_count=20.
- First post-reset fetch at 32'hBFC00008 -> fail=1, err_code=4, cycle_count=0.
- Fetch at 32'hBFC00006 while in RUN -> fail=1, err_code=3.
- Halt reached with SETTLE_CYCLES=3 and clk_enable low for 5 cycles inside SETTLE, then reset pulsed 2 cycles after pass:
  - verdict is delayed exactly 5 cycles;
  - pass=1;
  - the reset clears all outputs to 0 on the next edge.
